// File: rtl/bram_arb_pkg.sv
// Shared definitions for the framebuffer BRAM port arbiter: port-op encoding,
// frame geometry and default bus widths.
package bram_arb_pkg;

  typedef enum logic [1:0] {
    OP_IDLE = 2'd0,
    OP_RD   = 2'd1,
    OP_WR   = 2'd2
  } op_e;

  localparam int HSIZE          = 640;
  localparam int VSIZE          = 480;
  localparam int DEF_ADDR_W     = 19;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_WQ_DEPTH   = 4;

endpackage

// File: rtl/bram_port_arbiter_if.sv
// Signal bundle between the arbiter, the scan-out reader, the host writer and the BRAM.
// Optional WR_STALL_CNT exists only when BRAM_ARB_STATS_EN is defined.
interface bram_port_arbiter_if
  import bram_arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int WQ_DEPTH = DEF_WQ_DEPTH
) ();
  localparam int LVL_W = $clog2(WQ_DEPTH) + 1;

  logic              RD_REQ;
  logic [ADDR_W-1:0] RD_ADDR;
  logic              RD_VALID;
  logic [DATA_W-1:0] RD_DATA;
  // Host write handshake: a word transfers on a CLK edge where WR_VALID and
  // WR_READY are both 1; WR_READY never depends on WR_VALID in the same cycle.
  logic              WR_VALID;
  logic              WR_READY;
  logic [ADDR_W-1:0] WR_ADDR;
  logic [DATA_W-1:0] WR_DATA;
  logic [LVL_W-1:0]  WQ_LEVEL;
  logic              BRAM_EN;
  logic              BRAM_WE;
  logic [ADDR_W-1:0] BRAM_ADDR;
  logic [DATA_W-1:0] BRAM_DIN;
  logic [DATA_W-1:0] BRAM_DOUT;
  op_e               OP_STATE;
`ifdef BRAM_ARB_STATS_EN
  logic [15:0]       WR_STALL_CNT;
`endif

  modport slave (
    input  RD_REQ, RD_ADDR, WR_VALID, WR_ADDR, WR_DATA, BRAM_DOUT,
    output RD_VALID, RD_DATA, WR_READY, WQ_LEVEL,
           BRAM_EN, BRAM_WE, BRAM_ADDR, BRAM_DIN, OP_STATE
`ifdef BRAM_ARB_STATS_EN
    , output WR_STALL_CNT
`endif
  );

  modport master (
    output RD_REQ, RD_ADDR, WR_VALID, WR_ADDR, WR_DATA, BRAM_DOUT,
    input  RD_VALID, RD_DATA, WR_READY, WQ_LEVEL,
           BRAM_EN, BRAM_WE, BRAM_ADDR, BRAM_DIN, OP_STATE
`ifdef BRAM_ARB_STATS_EN
    , input WR_STALL_CNT
`endif
  );

endinterface

// File: rtl/bram_arb_wfifo.sv
// Synchronous write-queue FIFO holding {addr, data} entries; DEPTH must be a
// power of 2 so the pointers wrap naturally.
module bram_arb_wfifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  assign dout  = mem[rd_ptr];
  assign full  = (level == LVL_W'(DEPTH));
  assign empty = (level == '0);

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Callers guarantee no push when full and no pop when empty.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Single-port framebuffer BRAM arbiter: scan-out reads always win, queued host
// writes drain on idle cycles. BRAM_ARB_STATS_EN adds the WR_STALL_CNT counter.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int WQ_DEPTH = DEF_WQ_DEPTH
) (
  input  logic              CLK,
  input  logic              RESET_N,
  bram_port_arbiter_if.slave bus
);
  localparam int LVL_W = $clog2(WQ_DEPTH) + 1;
  localparam int FW    = ADDR_W + DATA_W;

  op_e              op_q;
  op_e              op_d;
  logic             ready_en;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [FW-1:0]    fifo_dout;
  logic [LVL_W-1:0] level;
  logic             rd_pend;

  // ready_en keeps WR_READY low while in reset and for the release edge itself.
  assign bus.WR_READY = ready_en & ~fifo_full;
  assign push         = bus.WR_VALID & bus.WR_READY;
  assign pop          = (op_d == OP_WR);
  assign bus.WQ_LEVEL = level;
  assign bus.OP_STATE = op_q;

  bram_arb_wfifo #(
    .WIDTH (FW),
    .DEPTH (WQ_DEPTH),
    .LVL_W (LVL_W)
  ) u_wfifo (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .push    (push),
    .pop     (pop),
    .din     ({bus.WR_ADDR, bus.WR_DATA}),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  always_comb begin
    op_d = OP_IDLE;
    if (bus.RD_REQ)       op_d = OP_RD;
    else if (!fifo_empty) op_d = OP_WR;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) op_q <= OP_IDLE;
    else          op_q <= op_d;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ready_en      <= 1'b0;
      bus.BRAM_EN   <= 1'b0;
      bus.BRAM_WE   <= 1'b0;
      bus.BRAM_ADDR <= '0;
      bus.BRAM_DIN  <= '0;
      rd_pend       <= 1'b0;
      bus.RD_VALID  <= 1'b0;
      bus.RD_DATA   <= '0;
    end else begin
      ready_en      <= 1'b1;
      bus.BRAM_EN   <= (op_d != OP_IDLE);
      bus.BRAM_WE   <= (op_d == OP_WR);
      bus.BRAM_ADDR <= (op_d == OP_WR) ? fifo_dout[FW-1:DATA_W] : bus.RD_ADDR;
      bus.BRAM_DIN  <= (op_d == OP_WR) ? fifo_dout[DATA_W-1:0] : '0;
      // BRAM_DOUT is valid the cycle after an enabled read; capture it then.
      rd_pend       <= (op_q == OP_RD);
      bus.RD_VALID  <= rd_pend;
      if (rd_pend) bus.RD_DATA <= bus.BRAM_DOUT;
    end
  end

`ifdef BRAM_ARB_STATS_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)
      stall_cnt <= '0;
    else if (bus.WR_VALID && !bus.WR_READY && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end

  assign bus.WR_STALL_CNT = stall_cnt;
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter: vector table for read latency and write
// drain, hand sequences for full/stall, push+pop, preemption and mid-run reset.
module tb_bram_port_arbiter;
  import bram_arb_pkg::*;

  localparam int ADDR_W   = 19;
  localparam int DATA_W   = 16;
  localparam int WQ_DEPTH = 4;
  localparam int LVL_W    = 3;

  logic CLK;
  logic RESET_N;

  bram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WQ_DEPTH(WQ_DEPTH)) bus ();

  bram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WQ_DEPTH(WQ_DEPTH)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- BRAM model: unwritten words read back their own address ----
  logic [DATA_W-1:0] bram_mem [int];

  initial bus.BRAM_DOUT = '0;
  always @(posedge CLK) begin
    if (bus.BRAM_EN) begin
      if (bus.BRAM_WE) bram_mem[int'(bus.BRAM_ADDR)] = bus.BRAM_DIN;
      else bus.BRAM_DOUT <= bram_mem.exists(int'(bus.BRAM_ADDR)) ?
                            bram_mem[int'(bus.BRAM_ADDR)] : bus.BRAM_ADDR[DATA_W-1:0];
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [ADDR_W+DATA_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (bus.BRAM_EN === 1'b1 && bus.BRAM_WE === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write (t=%0t)",
                 bus.BRAM_ADDR, bus.BRAM_DIN, $time);
      end else begin
        check("write_order", {bus.BRAM_ADDR, bus.BRAM_DIN}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver ----------------
  // Inputs change at the falling edge; outputs are checked at the next falling edge.
  task automatic drive(input logic rd, input logic [ADDR_W-1:0] ra, input logic wv,
                       input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                       input logic acc);
    bus.RD_REQ   = rd;
    bus.RD_ADDR  = ra;
    bus.WR_VALID = wv;
    bus.WR_ADDR  = wa;
    bus.WR_DATA  = wd;
    if (wv && acc) exp_q.push_back({wa, wd});
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    bus.RD_REQ   = 1'b0;
    bus.RD_ADDR  = '0;
    bus.WR_VALID = 1'b0;
    bus.WR_ADDR  = '0;
    bus.WR_DATA  = '0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              e_rd_valid;
    logic [DATA_W-1:0] e_rd_data;
    logic              e_en;
    logic              e_we;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_din;
    logic [LVL_W-1:0]  e_level;
    logic              e_ready;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk_wr(input logic wv, input logic [ADDR_W-1:0] wa,
                                 input logic [DATA_W-1:0] wd, input logic en,
                                 input logic [ADDR_W-1:0] ea, input logic [DATA_W-1:0] ed,
                                 input logic [LVL_W-1:0] lvl);
    vec_t v;
    v.rd_req = 1'b0;  v.rd_addr = '0;
    v.wr_valid = wv;  v.wr_addr = wa;  v.wr_data = wd;
    v.e_rd_valid = 1'b0;  v.e_rd_data = '0;
    v.e_en = en;  v.e_we = en;  v.e_addr = ea;  v.e_din = ed;
    v.e_level = lvl;  v.e_ready = 1'b1;
    return v;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    RESET_N = 1'b0;
    idle_inputs();

    // Read stream 0..9: BRAM_EN one edge later, RD_VALID/RD_DATA two edges later.
    for (int i = 0; i < 13; i++) begin
      vecs[i].rd_req     = (i < 10);
      vecs[i].rd_addr    = ADDR_W'(i);
      vecs[i].wr_valid   = 1'b0;
      vecs[i].wr_addr    = '0;
      vecs[i].wr_data    = '0;
      vecs[i].e_rd_valid = (i >= 2 && i <= 11);
      vecs[i].e_rd_data  = DATA_W'(i - 2);
      vecs[i].e_en       = (i < 10);
      vecs[i].e_we       = 1'b0;
      vecs[i].e_addr     = ADDR_W'(i);
      vecs[i].e_din      = '0;
      vecs[i].e_level    = '0;
      vecs[i].e_ready    = 1'b1;
    end
    // Three pushes with no reads: writes issue on consecutive cycles.
    vecs[13] = mk_wr(1'b1, 19'h100, 16'hF800, 1'b0, 19'h000, 16'h0000, 3'd1);
    vecs[14] = mk_wr(1'b1, 19'h101, 16'h07E0, 1'b1, 19'h100, 16'hF800, 3'd1);
    vecs[15] = mk_wr(1'b1, 19'h102, 16'h001F, 1'b1, 19'h101, 16'h07E0, 3'd1);
    vecs[16] = mk_wr(1'b0, 19'h000, 16'h0000, 1'b1, 19'h102, 16'h001F, 3'd0);
    vecs[17] = mk_wr(1'b0, 19'h000, 16'h0000, 1'b0, 19'h000, 16'h0000, 3'd0);

    // Test 1: reset holds every output at 0 while inputs toggle.
    for (int c = 0; c < 4; c++) begin
      bus.RD_REQ   = 1'($urandom_range(0, 1));
      bus.RD_ADDR  = ADDR_W'($urandom_range(0, 307199));
      bus.WR_VALID = 1'($urandom_range(0, 1));
      bus.WR_ADDR  = ADDR_W'($urandom_range(0, 307199));
      bus.WR_DATA  = DATA_W'($urandom_range(0, 65535));
      @(negedge CLK);
      check("reset_outputs", {bus.RD_VALID, bus.RD_DATA, bus.WR_READY, bus.WQ_LEVEL,
                              bus.BRAM_EN, bus.BRAM_WE, bus.BRAM_ADDR, bus.BRAM_DIN}, 64'd0);
    end
    idle_inputs();
    RESET_N = 1'b1;
    @(negedge CLK);
    check("release_ready", bus.WR_READY, 1);
    check("release_level", bus.WQ_LEVEL, 0);

    // Tests 2 and 3 from the table.
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].rd_req, vecs[i].rd_addr, vecs[i].wr_valid,
            vecs[i].wr_addr, vecs[i].wr_data, vecs[i].wr_valid);
      check($sformatf("v%0d_rd_valid", i), bus.RD_VALID, vecs[i].e_rd_valid);
      if (vecs[i].e_rd_valid) check($sformatf("v%0d_rd_data", i), bus.RD_DATA, vecs[i].e_rd_data);
      check($sformatf("v%0d_bram_en", i), bus.BRAM_EN, vecs[i].e_en);
      check($sformatf("v%0d_bram_we", i), bus.BRAM_WE, vecs[i].e_we);
      if (vecs[i].e_en) check($sformatf("v%0d_bram_addr", i), bus.BRAM_ADDR, vecs[i].e_addr);
      if (vecs[i].e_we) check($sformatf("v%0d_bram_din", i), bus.BRAM_DIN, vecs[i].e_din);
      check($sformatf("v%0d_level", i), bus.WQ_LEVEL, vecs[i].e_level);
      check($sformatf("v%0d_ready", i), bus.WR_READY, vecs[i].e_ready);
    end

    // Test 4: reads hold the port, queue fills, then drains when reads stop.
    for (int k = 0; k < 6; k++) begin
      check($sformatf("stall_ready_%0d", k), bus.WR_READY, (k < 4));
      drive(1'b1, ADDR_W'(32'h40 + k), 1'b1, ADDR_W'(32'h200 + k),
            DATA_W'(32'hA000 + k * 3), (k < 4));
      check($sformatf("stall_level_%0d", k), bus.WQ_LEVEL, (k < 4) ? k + 1 : 4);
      check($sformatf("stall_we_%0d", k), bus.BRAM_WE, 0);
    end
    check("stall_ready_full", bus.WR_READY, 0);
`ifdef BRAM_ARB_STATS_EN
    check("stall_cnt", bus.WR_STALL_CNT, 2);
`endif
    for (int j = 0; j < 4; j++) begin
      drive(1'b0, '0, 1'b0, '0, '0, 1'b0);
      check($sformatf("drain_we_%0d", j), bus.BRAM_WE, 1);
      check($sformatf("drain_level_%0d", j), bus.WQ_LEVEL, 3 - j);
      check($sformatf("drain_ready_%0d", j), bus.WR_READY, 1);
    end
    drive(1'b0, '0, 1'b0, '0, '0, 1'b0);
    check("drain_idle_en", bus.BRAM_EN, 0);
    check("drain_queue_empty", exp_q.size(), 0);

    // Test 5: push+pop keeps level; a read preempts exactly one pop.
    drive(1'b1, 19'h10, 1'b1, 19'h300, 16'h1111, 1'b1);
    drive(1'b1, 19'h11, 1'b1, 19'h301, 16'h2222, 1'b1);
    check("simul_pre_level", bus.WQ_LEVEL, 2);
    drive(1'b0, '0, 1'b1, 19'h302, 16'h3333, 1'b1);
    check("simul_level", bus.WQ_LEVEL, 2);
    check("simul_we", bus.BRAM_WE, 1);
    drive(1'b1, 19'h12, 1'b0, '0, '0, 1'b0);
    check("preempt_we", bus.BRAM_WE, 0);
    check("preempt_en", bus.BRAM_EN, 1);
    check("preempt_op", bus.OP_STATE, OP_RD);
    check("preempt_level", bus.WQ_LEVEL, 2);
    drive(1'b0, '0, 1'b0, '0, '0, 1'b0);
    check("resume_we_a", bus.BRAM_WE, 1);
    check("resume_level_a", bus.WQ_LEVEL, 1);
    drive(1'b0, '0, 1'b0, '0, '0, 1'b0);
    check("resume_we_b", bus.BRAM_WE, 1);
    check("resume_level_b", bus.WQ_LEVEL, 0);
    drive(1'b0, '0, 1'b0, '0, '0, 1'b0);
    check("resume_idle", bus.BRAM_EN, 0);

    // Test 6: reset with three queued writes and reads in flight.
    for (int k = 0; k < 3; k++)
      drive(1'b1, ADDR_W'(32'h20 + k), 1'b1, ADDR_W'(32'h400 + k), DATA_W'(32'h5A00 + k), 1'b1);
    check("mid_pre_level", bus.WQ_LEVEL, 3);
    RESET_N = 1'b0;
    exp_q.delete();
    idle_inputs();
    #1;
    check("mid_rst_valid", bus.RD_VALID, 0);
    check("mid_rst_en", bus.BRAM_EN, 0);
    check("mid_rst_level", bus.WQ_LEVEL, 0);
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      check("mid_hold_valid", bus.RD_VALID, 0);
      check("mid_hold_we", bus.BRAM_WE, 0);
    end
    RESET_N = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      check("post_valid", bus.RD_VALID, 0);
      check("post_we", bus.BRAM_WE, 0);
      check("post_level", bus.WQ_LEVEL, 0);
      check("post_ready", bus.WR_READY, 1);
    end
`ifdef BRAM_ARB_STATS_EN
    check("post_stall_cnt", bus.WR_STALL_CNT, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
